pf_ddr3_ca_dly_ctrl: RTL and testbench

//  Per-lane output-delay controller for DDR3 address/command pads. Sits directly upstream of the
//  PHY IOD lane and drives its DELAY_LINE_LOAD/MOVE/DIRECTION inputs. Converts a target-tap request

---
 rtl/pf_ddr3_phy_pkg.sv | 28 ++
 rtl/pf_ddr3_ca_dly_ctrl_if.sv | 29 ++
 rtl/pf_ddr3_dly_settle_timer.sv | 44 ++++
 rtl/pf_ddr3_ca_dly_ctrl.sv | 154 +++++++++++++++
 tb/tb_pf_ddr3_ca_dly_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pf_ddr3_phy_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pf_ddr3_phy_pkg : shared types and defaults for the DDR3 CA delay control   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package pf_ddr3_phy_pkg;

  localparam int DLY_TAP_W_DFLT    = 8;
  localparam int DLY_INIT_TAP_DFLT = 1;

  typedef enum logic [2:0] {
    ST_AUTOLOAD = 3'd0,
    ST_LOAD     = 3'd1,
    ST_LSETTLE  = 3'd2,
    ST_IDLE     = 3'd3,
    ST_PREP     = 3'd4,
    ST_MOVE     = 3'd5,
    ST_SETTLE   = 3'd6,
    ST_FIN      = 3'd7
  } dly_state_t;

  // Counter width able to hold a settle count of 'cycles'.
  function automatic int settle_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pf_ddr3_ca_dly_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pf_ddr3_ca_dly_ctrl_if : request/status bundle of the CA delay controller   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface pf_ddr3_ca_dly_ctrl_if #(
  parameter int TAP_W = pf_ddr3_phy_pkg::DLY_TAP_W_DFLT
);

  logic             REQ_VALID;
  logic [TAP_W-1:0] REQ_TAP;
  logic             LOAD_REQ;
  logic             REQ_READY;
  logic             DONE;
  logic             ERR;
  logic [TAP_W-1:0] CUR_TAP;

  modport master (
    output REQ_VALID, REQ_TAP, LOAD_REQ,
    input  REQ_READY, DONE, ERR, CUR_TAP
  );

  modport slave (
    input  REQ_VALID, REQ_TAP, LOAD_REQ,
    output REQ_READY, DONE, ERR, CUR_TAP
  );

endinterface
`default_nettype wire

// File: rtl/pf_ddr3_dly_settle_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pf_ddr3_dly_settle_timer : loadable down-counter, expires SETTLE_CYCLES     |
// | cycles after start. Rev 1.0                                                 |
// +-----------------------------------------------------------------------------+
module pf_ddr3_dly_settle_timer
  import pf_ddr3_phy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic expire_o
);

  localparam int              CNT_W  = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Expire is asserted during the last settle cycle so the controller can act
  // on the following edge without an extra idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= RELOAD;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign expire_o = busy_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pf_ddr3_ca_dly_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pf_ddr3_ca_dly_ctrl : per-lane IOD output-delay controller, turns a target  |
// | tap into paced single-tap moves and tracks the current tap. Rev 1.0         |
// +-----------------------------------------------------------------------------+
module pf_ddr3_ca_dly_ctrl
  import pf_ddr3_phy_pkg::*;
#(
  parameter int TAP_W         = DLY_TAP_W_DFLT,
  parameter int TAP_MAX       = 255,
  parameter int INIT_TAP      = DLY_INIT_TAP_DFLT,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  FAB_CLK,
  input  logic                  TX_SYNC_RST,
  pf_ddr3_ca_dly_ctrl_if.slave  req,
  output logic                  DELAY_LINE_LOAD_0,
  output logic                  DELAY_LINE_MOVE_0,
  output logic                  DELAY_LINE_DIRECTION_0,
  input  logic                  DELAY_LINE_OUT_OF_RANGE_0
);

  localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);

  dly_state_t       state_q;
  logic [TAP_W-1:0] cur_tap_q;
  logic [TAP_W-1:0] target_q;
  logic             dir_q;
  logic             move_q;
  logic             load_q;
  logic             done_q;
  logic             ready_q;
  logic             err_q;

  logic             settle_start;
  logic             settle_expire;
  logic             tap_out_of_range;
  logic [TAP_W-1:0] step_tap;

  assign settle_start     = (state_q == ST_MOVE) || (state_q == ST_LOAD);
  assign tap_out_of_range = 32'(req.REQ_TAP) > 32'(TAP_MAX);
  assign step_tap         = dir_q ? (cur_tap_q + TAP_W'(1)) : (cur_tap_q - TAP_W'(1));

  pf_ddr3_dly_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk_i    (FAB_CLK),
    .rst_i    (TX_SYNC_RST),
    .start_i  (settle_start),
    .expire_o (settle_expire)
  );

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q   <= ST_AUTOLOAD;
      cur_tap_q <= INIT_TAP_V;
      target_q  <= '0;
      dir_q     <= 1'b0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      move_q <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_AUTOLOAD: begin
          load_q  <= 1'b1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          state_q <= ST_LSETTLE;
        end
        ST_LSETTLE: begin
          if (settle_expire) begin
            cur_tap_q <= INIT_TAP_V;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= ST_FIN;
          end
        end
        // FIN accepts exactly like IDLE so requests can be issued back-to-back.
        ST_IDLE, ST_FIN: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          if (req.LOAD_REQ) begin
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            load_q  <= 1'b1;
            state_q <= ST_LOAD;
          end else if (req.REQ_VALID) begin
            if (tap_out_of_range) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else if (req.REQ_TAP == cur_tap_q) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              err_q    <= 1'b0;
              ready_q  <= 1'b0;
              target_q <= req.REQ_TAP;
              dir_q    <= req.REQ_TAP > cur_tap_q;
              state_q  <= ST_PREP;
            end
          end
        end
        ST_PREP: begin
          move_q  <= 1'b1;
          state_q <= ST_MOVE;
        end
        ST_MOVE: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_expire) begin
            if (DELAY_LINE_OUT_OF_RANGE_0) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              cur_tap_q <= step_tap;
              if (step_tap == target_q) begin
                done_q  <= 1'b1;
                ready_q <= 1'b1;
                state_q <= ST_FIN;
              end else begin
                move_q  <= 1'b1;
                state_q <= ST_MOVE;
              end
            end
          end
        end
        default: begin
          state_q <= ST_AUTOLOAD;
        end
      endcase
    end
  end

  assign req.REQ_READY          = ready_q;
  assign req.DONE               = done_q;
  assign req.ERR                = err_q;
  assign req.CUR_TAP            = cur_tap_q;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pf_ddr3_ca_dly_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pf_ddr3_ca_dly_ctrl : directed self-checking bench for the CA delay ctrl |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_pf_ddr3_ca_dly_ctrl;

  localparam int TW     = 9;
  localparam int PERIOD = 5;  // 1 MOVE cycle + 4 settle cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic oor = 1'b0;
  logic ld;
  logic mv;
  logic dir;

  int n_run  = 0;
  int n_fail = 0;

  pf_ddr3_ca_dly_ctrl_if #(.TAP_W(TW)) bus ();

  always #5 clk = ~clk;

  pf_ddr3_ca_dly_ctrl #(
    .TAP_W         (TW),
    .TAP_MAX       (255),
    .INIT_TAP      (1),
    .SETTLE_CYCLES (4)
  ) u_dut (
    .FAB_CLK                   (clk),
    .TX_SYNC_RST               (rst),
    .req                       (bus),
    .DELAY_LINE_LOAD_0         (ld),
    .DELAY_LINE_MOVE_0         (mv),
    .DELAY_LINE_DIRECTION_0    (dir),
    .DELAY_LINE_OUT_OF_RANGE_0 (oor)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load"},  32'(ld), 0);
    check({tag, "_move"},  32'(mv), 0);
    check({tag, "_dir"},   32'(dir), 0);
    check({tag, "_ready"}, 32'(bus.REQ_READY), 0);
    check({tag, "_done"},  32'(bus.DONE), 0);
    check({tag, "_err"},   32'(bus.ERR), 0);
    check({tag, "_cur"},   32'(bus.CUR_TAP), 1);
  endtask

  // Observation i = i-th sample (#1 after an edge) following the release edge.
  task automatic release_autoload(input string tag);
    int load_at     = 0;
    int done_at     = 0;
    int ready_early = 0;
    rst = 1'b0;
    for (int i = 1; i <= 50 && done_at == 0; i++) begin
      tick();
      if (ld && load_at == 0) load_at = i;
      if (bus.DONE) done_at = i;
      else if (bus.REQ_READY) ready_early++;
    end
    check({tag, "_load_at"},     32'(load_at), 1);
    check({tag, "_done_at"},     32'(done_at), 6);
    check({tag, "_ready_early"}, 32'(ready_early), 0);
    check({tag, "_ready_done"},  32'(bus.REQ_READY), 1);
    check({tag, "_cur"},         32'(bus.CUR_TAP), 1);
  endtask

  // Issues one request; observation i is taken #1 after edge t0+i-1 (spec time t0+i).
  task automatic run_op(input bit is_load, input int tap, input bit chk_dir, input bit exp_dir,
                        input bit oor_first, input int abort_at,
                        output int done_at, output int moves, output int move_bad,
                        output int load_at, output int dir_bad, output int err_first);
    int waited = 0;
    int i      = 1;
    while (!bus.REQ_READY && waited < 60) begin
      tick();
      waited++;
    end
    if (!bus.REQ_READY) check("ready_timeout", 32'(bus.REQ_READY), 1);
    bus.REQ_VALID = 1'b1;
    bus.LOAD_REQ  = is_load;
    bus.REQ_TAP   = TW'(tap);
    tick();
    bus.REQ_VALID = 1'b0;
    bus.LOAD_REQ  = 1'b0;
    done_at   = 0;
    moves     = 0;
    move_bad  = 0;
    load_at   = 0;
    dir_bad   = 0;
    err_first = int'(bus.ERR);
    while (done_at == 0 && i <= 200) begin
      if (mv) begin
        moves++;
        if (i != 2 + (moves - 1) * PERIOD) move_bad++;
      end
      if (ld && load_at == 0) load_at = i;
      if (chk_dir && dir !== exp_dir) dir_bad++;
      if (oor_first && i == 2) oor = 1'b1;
      if (bus.DONE) begin
        done_at = i;
        oor     = 1'b0;
      end else if (abort_at == i) begin
        rst = 1'b1;
        tick();
        done_at = -1;
      end else begin
        tick();
        i++;
      end
    end
  endtask

  initial begin
    int d, m, mb, l, db, e;
    bus.REQ_VALID = 1'b0;
    bus.LOAD_REQ  = 1'b0;
    bus.REQ_TAP   = '0;

    // Reset state and auto-load
    tick();
    tick();
    check_reset_vals("t1_rst");
    release_autoload("t1");

    // 1 -> 4, increment
    run_op(1'b0, 4, 1'b1, 1'b1, 1'b0, 0, d, m, mb, l, db, e);
    check("t2_done_at", 32'(d), 17);
    check("t2_moves",   32'(m), 3);
    check("t2_movepos", 32'(mb), 0);
    check("t2_dir",     32'(db), 0);
    check("t2_load",    32'(l), 0);
    check("t2_cur",     32'(bus.CUR_TAP), 4);
    check("t2_err",     32'(bus.ERR), 0);
    check("t2_ready",   32'(bus.REQ_READY), 1);

    // 4 -> 2, decrement; then zero-distance request
    run_op(1'b0, 2, 1'b1, 1'b0, 1'b0, 0, d, m, mb, l, db, e);
    check("t3_done_at", 32'(d), 12);
    check("t3_moves",   32'(m), 2);
    check("t3_movepos", 32'(mb), 0);
    check("t3_dir",     32'(db), 0);
    check("t3_cur",     32'(bus.CUR_TAP), 2);
    run_op(1'b0, 2, 1'b0, 1'b0, 1'b0, 0, d, m, mb, l, db, e);
    check("t3z_done_at", 32'(d), 1);
    check("t3z_moves",   32'(m), 0);
    check("t3z_cur",     32'(bus.CUR_TAP), 2);

    // 2 -> 1, then 1 -> 0 with the line reporting out-of-range
    run_op(1'b0, 1, 1'b1, 1'b0, 1'b0, 0, d, m, mb, l, db, e);
    check("t4p_done_at", 32'(d), 7);
    check("t4p_cur",     32'(bus.CUR_TAP), 1);
    run_op(1'b0, 0, 1'b1, 1'b0, 1'b1, 0, d, m, mb, l, db, e);
    check("t4_done_at", 32'(d), 7);
    check("t4_moves",   32'(m), 1);
    check("t4_dir",     32'(db), 0);
    check("t4_err",     32'(bus.ERR), 1);
    check("t4_cur",     32'(bus.CUR_TAP), 1);

    // LOAD_REQ and REQ_VALID together: load wins, ERR cleared on accept
    run_op(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, d, m, mb, l, db, e);
    check("t5_err_clr",  32'(e), 0);
    check("t5_load_at",  32'(l), 1);
    check("t5_done_at",  32'(d), 6);
    check("t5_moves",    32'(m), 0);
    check("t5_cur",      32'(bus.CUR_TAP), 1);

    // Target above TAP_MAX
    run_op(1'b0, 300, 1'b0, 1'b0, 1'b0, 0, d, m, mb, l, db, e);
    check("t5r_err",     32'(e), 1);
    check("t5r_done_at", 32'(d), 1);
    check("t5r_moves",   32'(m), 0);
    check("t5r_load",    32'(l), 0);
    check("t5r_cur",     32'(bus.CUR_TAP), 1);

    // Reset during the 2nd settle of a 1 -> 4 move
    run_op(1'b0, 4, 1'b1, 1'b1, 1'b0, 9, d, m, mb, l, db, e);
    check("t6_err_clr", 32'(e), 0);
    check("t6_moves",   32'(m), 2);
    check("t6_movepos", 32'(mb), 0);
    check("t6_abort",   32'(d), 32'(-1));
    check_reset_vals("t6_rst");
    release_autoload("t6");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
